// File: rtl/regfile_hazard_ctrl.sv
// Issue/stall controller for an in-order pipeline: register scoreboard for RAW/WAW
// interlocks, a single multi-cycle divide unit tracker and a saturating stall counter.
//
// state  | meaning
// S_IDLE | divide unit free; a divide may issue
// S_BUSY | divide in flight; div_cnt counts down to completion
module regfile_hazard_ctrl #(
    parameter int DIV_LATENCY = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_write,
    input  logic        id_is_div,
    input  logic        ex_redirect,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    output logic        issue,
    output logic        stall,
    output logic        flush_id,
    output logic        bubble_ex,
    output logic        div_start,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] stall_cycles
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } div_state_e;

    div_state_e  state_q, state_d;
    logic [5:0]  div_cnt_q, div_cnt_d;
    logic [31:0] sb_q, sb_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        run_q;
    logic        raw, waw, struct_haz;

    // run_q rises on the first edge after reset release, so state first moves on the second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    always_comb begin
        raw = id_valid & ((id_uses_rs1 & (id_rs1 != 5'd0) & sb_q[id_rs1]) |
                          (id_uses_rs2 & (id_rs2 != 5'd0) & sb_q[id_rs2]));
        waw = id_valid & id_reg_write & (id_rd != 5'd0) & sb_q[id_rd];
        struct_haz = id_valid & id_is_div & div_busy;
    end

    assign div_busy     = (state_q == S_BUSY);
    assign div_done     = div_busy & (div_cnt_q == 6'd1);
    assign issue        = run_q & id_valid & ~raw & ~waw & ~struct_haz & ~ex_redirect;
    assign stall        = run_q & id_valid & (raw | waw | struct_haz) & ~ex_redirect;
    assign flush_id     = ex_redirect;
    assign bubble_ex    = ~issue;
    assign div_start    = issue & id_is_div & (state_q == S_IDLE);
    assign stall_cycles = stall_cnt_q;

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (div_start) begin
                    div_cnt_d = 6'(DIV_LATENCY);
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                if (div_cnt_q == 6'd1) begin
                    div_cnt_d = 6'd0;
                    state_d   = S_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q - 6'd1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                div_cnt_d = 6'd0;
            end
        endcase
    end

    // Clear is applied before set so an issuing writer wins over a same-index writeback.
    always_comb begin
        sb_d = sb_q;
        if (wb_reg_write) sb_d[wb_rd] = 1'b0;
        if (issue && id_reg_write) sb_d[id_rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= 6'd0;
            sb_q        <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else if (run_q) begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_regfile_hazard_ctrl.sv
// Scoreboard bench for regfile_hazard_ctrl: a cycle-level reference model pushes expected
// outputs into a queue; a negedge monitor pops and compares against the DUT.
module tb_regfile_hazard_ctrl;

    localparam int LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_is_div;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        ex_redirect, wb_reg_write;
    logic        issue, stall, flush_id, bubble_ex, div_start, div_busy, div_done;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    regfile_hazard_ctrl #(.DIV_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_div(id_is_div),
        .ex_redirect(ex_redirect), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .issue(issue), .stall(stall), .flush_id(flush_id), .bubble_ex(bubble_ex),
        .div_start(div_start), .div_busy(div_busy), .div_done(div_done),
        .stall_cycles(stall_cycles)
    );

    typedef struct packed {
        logic        issue, stall, flush_id, bubble_ex, div_start, div_busy, div_done;
        logic [31:0] stall_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: set of in-flight destinations, divide tracked by its start cycle.
    bit          m_inflight[32];
    bit          m_run;
    bit          m_div_active;
    int          m_div_start_cyc;
    int          m_cyc;
    logic [31:0] m_stall_cnt;
    bit          last_issue, last_stall;

    task automatic model_reset();
        foreach (m_inflight[i]) m_inflight[i] = 1'b0;
        m_run        = 1'b0;
        m_div_active = 1'b0;
        m_stall_cnt  = 32'd0;
    endtask

    task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_field("issue",        {31'd0, issue},     {31'd0, e.issue});
            check_field("stall",        {31'd0, stall},     {31'd0, e.stall});
            check_field("flush_id",     {31'd0, flush_id},  {31'd0, e.flush_id});
            check_field("bubble_ex",    {31'd0, bubble_ex}, {31'd0, e.bubble_ex});
            check_field("div_start",    {31'd0, div_start}, {31'd0, e.div_start});
            check_field("div_busy",     {31'd0, div_busy},  {31'd0, e.div_busy});
            check_field("div_done",     {31'd0, div_done},  {31'd0, e.div_done});
            check_field("stall_cycles", stall_cycles,       e.stall_cycles);
        end
    end

    // One pipeline cycle: apply inputs, predict outputs, advance the model at the edge.
    task automatic drive(input bit r, input bit v,
                         input logic [4:0] rs1, input bit u1,
                         input logic [4:0] rs2, input bit u2,
                         input logic [4:0] rd, input bit rw, input bit dv,
                         input bit redir, input bit wbw, input logic [4:0] wbr);
        exp_t e;
        bit   haz, busy, done, go;
        rst_n = r; id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_is_div = dv; ex_redirect = redir;
        wb_reg_write = wbw; wb_rd = wbr;
        if (!r) model_reset();
        busy = m_div_active && (m_cyc > m_div_start_cyc) && (m_cyc <= m_div_start_cyc + LAT);
        done = m_div_active && (m_cyc == m_div_start_cyc + LAT);
        haz  = (u1 && rs1 != 0 && m_inflight[rs1]) || (u2 && rs2 != 0 && m_inflight[rs2]) ||
               (rw && rd != 0 && m_inflight[rd]) || (dv && busy);
        go   = r && m_run;
        e.issue        = go && v && !haz && !redir;
        e.stall        = go && v && haz && !redir;
        e.flush_id     = redir;
        e.bubble_ex    = !e.issue;
        e.div_start    = e.issue && dv;
        e.div_busy     = busy;
        e.div_done     = done;
        e.stall_cycles = m_stall_cnt;
        exp_q.push_back(e);
        last_issue = e.issue;
        last_stall = e.stall;
        @(posedge clk);
        if (r) begin
            if (!m_run) begin
                m_run = 1'b1;
            end else begin
                if (wbw && wbr != 0) m_inflight[wbr] = 1'b0;
                if (e.issue && rw && rd != 0) m_inflight[rd] = 1'b1;
                if (done) m_div_active = 1'b0;
                if (e.div_start) begin
                    m_div_active    = 1'b1;
                    m_div_start_cyc = m_cyc;
                end
                if (e.stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 32'd1;
            end
        end
        m_cyc++;
        #1;
    endtask

    task automatic nop();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit          v, u1, u2, rw, dv, redir, wbw, rr;
        logic [4:0]  rs1, rs2, rd, wbr;
        bit          hold;
        m_cyc = 0;
        model_reset();
        rst_n = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rd = 0; id_reg_write = 0; id_is_div = 0; ex_redirect = 0; wb_reg_write = 0; wb_rd = 0;
        @(posedge clk); #1;

        // Reset with an active instruction presented, then release.
        repeat (3) drive(0, 1, 1, 1, 2, 1, 3, 1, 1, 0, 0, 0);
        drive(1, 1, 1, 1, 2, 1, 3, 1, 1, 0, 0, 0);

        // x0 reads and x0 writes never interlock.
        repeat (3) drive(1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);

        // RAW on x5 persists through the writeback cycle, issues the cycle after.
        drive(1, 1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0);
        repeat (3) drive(1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
        drive(1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 1, 5);
        drive(1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 1, 6);

        // Redirect overrides a RAW stall on x7 and leaves the scoreboard alone.
        drive(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        drive(1, 1, 7, 1, 0, 0, 8, 1, 0, 1, 0, 0);
        drive(1, 1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 0);
        drive(1, 1, 7, 1, 0, 0, 8, 1, 0, 0, 1, 7);
        drive(1, 1, 7, 1, 0, 0, 8, 1, 0, 0, 1, 8);

        // Writer of x9 issued while writeback also targets x9: set wins, next reader stalls.
        drive(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 1, 9);
        drive(1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 9, 1, 0, 0, 0, 0, 1, 9);
        drive(1, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0);

        // Back-to-back divides: second held until the cycle after div_done.
        drive(1, 1, 1, 1, 2, 1, 10, 1, 1, 0, 0, 0);
        repeat (LAT + 1) drive(1, 1, 1, 1, 2, 1, 11, 1, 1, 0, 0, 0);
        repeat (3) nop();

        // Reset mid-divide with x3 in flight and stalls accumulated.
        drive(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 1, 10);
        drive(1, 1, 0, 0, 0, 0, 12, 1, 1, 0, 1, 11);
        repeat (12) drive(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) drive(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (LAT + 4) drive(1, 1, 3, 1, 12, 1, 0, 0, 0, 0, 0, 0);

        // Randomized traffic; a stalled instruction is held in ID as real hardware would.
        hold = 0;
        v = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; rd = 0; rw = 0; dv = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!hold) begin
                v   = ($urandom_range(0, 9) < 8);
                rs1 = 5'($urandom_range(0, 7));
                rs2 = 5'($urandom_range(0, 7));
                u1  = $urandom_range(0, 1);
                u2  = $urandom_range(0, 1);
                rd  = 5'($urandom_range(0, 7));
                rw  = ($urandom_range(0, 3) != 0);
                dv  = ($urandom_range(0, 6) == 0);
            end
            redir = ($urandom_range(0, 9) == 0);
            wbw   = ($urandom_range(0, 9) < 4);
            wbr   = 5'($urandom_range(0, 7));
            rr    = ($urandom_range(0, 499) != 0);
            drive(rr, v, rs1, u1, rs2, u2, rd, rw, dv, redir, wbw, wbr);
            hold = last_stall;
        end
        repeat (2) nop();

        @(negedge clk); #1;
        check_field("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_hazard_ctrl.md
REGFILE_HAZARD_CTRL -- requirements
Module: regfile_hazard_ctrl

Interface
REQ-001 Parameter DIV_LATENCY, default 33, meaning cycles from div_start to the divide unit's result being ready (legal 2..63).
REQ-002 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 id_valid  in  1  ID stage holds a valid instruction.
REQ-005 id_rs1, id_rs2  in  5 each  source register indices decoded in ID.
REQ-006 id_uses_rs1, id_uses_rs2  in  1 each  instruction reads that source.
REQ-007 id_rd  in  5  destination index; id_reg_write  in  1  instruction writes id_rd.
REQ-008 id_is_div  in  1  instruction is a DIV/DIVU/REM/REMU (multi-cycle unit).
REQ-009 ex_redirect  in  1  taken branch/JAL/JALR resolved in EX this cycle.
REQ-010 wb_reg_write  in  1, wb_rd  in  5  register-file write port this cycle.
REQ-011 issue  out  1  ID instruction advances to EX this cycle.
REQ-012 stall  out  1  hold PC and IF/ID register.
REQ-013 flush_id  out  1  replace IF/ID contents with a bubble.
REQ-014 bubble_ex  out  1  insert NOP into ID/EX register.
REQ-015 div_start  out  1  one-cycle start pulse to the divide unit.
REQ-016 div_busy  out  1  divide unit occupied; div_done  out  1  one-cycle completion pulse.
REQ-017 stall_cycles  out  32  saturating count of cycles with stall=1.

Function
REQ-018 Block SHALL keep a 32-bit scoreboard sb; sb[n]=1 means a write to xn is in flight; sb[0] SHALL always read 0.
REQ-019 raw = id_valid & ((id_uses_rs1 & id_rs1!=0 & sb[id_rs1]) | (id_uses_rs2 & id_rs2!=0 & sb[id_rs2])).
REQ-020 waw = id_valid & id_reg_write & id_rd!=0 & sb[id_rd].
REQ-021 struct = id_valid & id_is_div & div_busy.
REQ-022 No WB bypass: register file reads are combinational from pre-edge state, so a hazard on xn SHALL persist in the cycle wb writes xn and clear the cycle after.
REQ-023 issue = id_valid & !raw & !waw & !struct & !ex_redirect (combinational).
REQ-024 stall = id_valid & (raw | waw | struct) & !ex_redirect.
REQ-025 flush_id = ex_redirect; bubble_ex = !issue.
REQ-026 ex_redirect SHALL override every stall: ID instruction discarded, no scoreboard set, no div_start.
REQ-027 On issue with id_reg_write & id_rd!=0, sb[id_rd] SHALL set at the next edge.
REQ-028 On wb_reg_write & wb_rd!=0, sb[wb_rd] SHALL clear at the next edge.
REQ-029 Same-cycle set and clear of the same index: set wins.
REQ-030 Divide FSM states IDLE, BUSY; div_cnt 6 bits.
REQ-031 IDLE: issue & id_is_div -> div_start=1 same cycle, load div_cnt=DIV_LATENCY, go BUSY.
REQ-032 BUSY: div_busy=1, div_cnt decrements each cycle; at div_cnt==1 assert div_done that cycle and return to IDLE next edge.
REQ-033 A divide issued in IDLE in the cycle div_done is asserted is impossible (struct holds); back-to-back divide issue occurs earliest the cycle after div_done.
REQ-034 ex_redirect SHALL NOT cancel an in-flight divide (older instruction).
REQ-035 stall_cycles SHALL increment when stall=1 and hold at 32'hFFFF_FFFF.
REQ-036 div_start, issue, stall, flush_id, bubble_ex SHALL depend only on current inputs and registered state (no combinational loops through div_cnt).

Reset
REQ-037 rst_n=0 SHALL immediately clear sb, div_cnt, stall_cycles, force IDLE; div_busy=0, div_done=0, div_start=0 while rst_n=0.
REQ-038 While in reset, issue=0 and stall=0 irrespective of inputs; reset mid-divide abandons it with no div_done.
REQ-039 Release of rst_n SHALL be taken synchronously; first valid update on the second rising edge after deassertion.

Verification
REQ-040 Issue ADD x5 (rd=5); next cycle ID uses rs1=5 -> stall=1, bubble_ex=1 until the cycle after wb_rd=5 write, then issue=1.
REQ-041 Reads of x0 with sb empty and instruction writing x0 -> issue=1, sb unchanged, no stall ever.
REQ-042 DIV issued (DIV_LATENCY=33) -> div_start pulse, div_busy 33 cycles, div_done on 33rd; second DIV held with stall=1 until cycle after div_done.
REQ-043 RAW stall on x7 with ex_redirect=1 same cycle -> flush_id=1, stall=0, issue=0, sb unchanged.
REQ-044 wb clears x9 and ID issues new writer of x9 same edge -> sb[9]=1 afterward.
REQ-045 rst_n pulsed low mid-divide with sb[3]=1 and stall_cycles=12 -> sb=0, div_busy=0, stall_cycles=0, no div_done.
